inst_decode_stage: RTL

- Pipeline stage between fetch and the integer ALU / execute stage of the RV32I core.
- Accepts one instruction per cycle from fetch over a valid/ready handshake.
- Decodes the opcode, funct3 and funct7 fields, the register indices and the sign-extended immediate, and presents them registered to execute.
- Holds a register scoreboard and stalls issue on read-after-write hazards until writeback clears them.

---
 rtl/inst_decode_stage_pkg.sv | 60 ++++++
 rtl/rv_imm_gen.sv | 25 ++
 rtl/inst_decode_stage.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/inst_decode_stage_pkg.sv
// Shared RV32I decode constants: opcodes, ALU funct3 codes, immediate formats
// and per-opcode register-usage helpers used by decode and the ALU.
package inst_decode_stage_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [2:0] {
    FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
  } imm_fmt_e;

  function automatic imm_fmt_e fmt_of(input logic [6:0] op);
    case (op)
      OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: fmt_of = FMT_I;
      OP_STORE:                                      fmt_of = FMT_S;
      OP_BRANCH:                                     fmt_of = FMT_B;
      OP_LUI, OP_AUIPC:                              fmt_of = FMT_U;
      OP_JAL:                                        fmt_of = FMT_J;
      default:                                       fmt_of = FMT_NONE;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH) ||
           (op == OP_IMM) || (op == OP_LOAD) || (op == OP_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_IMM) || (op == OP_LOAD) || (op == OP_JAL) ||
           (op == OP_JALR) || (op == OP_LUI) || (op == OP_AUIPC);
  endfunction

  function automatic logic is_rv32i(input logic [6:0] op);
    return writes_rd(op) || (op == OP_STORE) || (op == OP_BRANCH) ||
           (op == OP_FENCE) || (op == OP_SYSTEM);
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational RV32I immediate generator: picks the format from the opcode
// and sign-extends from inst[31]; formats without an immediate yield 0.
module rv_imm_gen
  import inst_decode_stage_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] imm
);

  imm_fmt_e fmt;

  always_comb begin
    fmt = fmt_of(inst[6:0]);
    imm = 32'd0;
    case (fmt)
      FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm = {inst[31:12], 12'd0};
      FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/inst_decode_stage.sv
// RV32I decode stage: registered decode toward execute plus a RAW scoreboard.
// Define DECODE_ILLEGAL_CHECK_EN to flag opcodes outside RV32I via ex_illegal.
module inst_decode_stage
  import inst_decode_stage_pkg::*;
#(
  parameter int NREG = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_inst,
  input  logic [31:0]     if_pc,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [31:0]     ex_pc,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic [RA_W-1:0] ex_rs1_addr,
  output logic [RA_W-1:0] ex_rs2_addr,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic            ex_rd_we,
  output logic [31:0]     ex_imm,
  output logic            ex_illegal,
  input  logic            wb_valid,
  input  logic [RA_W-1:0] wb_rd_addr
);

  logic [6:0]      dec_opcode;
  logic [RA_W-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [31:0]     dec_imm;
  logic            dec_illegal, dec_rd_we, dec_use_rs1, dec_use_rs2;
  logic            hazard, accept;

  logic [NREG-1:0] sb_reg, sb_next;

  logic            ex_valid_reg, ex_rd_we_reg, ex_illegal_reg;
  logic [31:0]     ex_pc_reg, ex_imm_reg;
  logic [6:0]      ex_opcode_reg, ex_funct7_reg;
  logic [2:0]      ex_funct3_reg;
  logic [RA_W-1:0] ex_rs1_reg, ex_rs2_reg, ex_rd_reg;

  assign dec_opcode = if_inst[6:0];
  assign dec_rd     = if_inst[11:7];
  assign dec_rs1    = if_inst[19:15];
  assign dec_rs2    = if_inst[24:20];

`ifdef DECODE_ILLEGAL_CHECK_EN
  assign dec_illegal = ~is_rv32i(dec_opcode);
`else
  assign dec_illegal = 1'b0;
`endif

  assign dec_rd_we   = writes_rd(dec_opcode) & (dec_rd != '0) & ~dec_illegal;
  assign dec_use_rs1 = uses_rs1(dec_opcode) & ~dec_illegal;
  assign dec_use_rs2 = uses_rs2(dec_opcode) & ~dec_illegal;

  rv_imm_gen u_imm_gen (
    .inst (if_inst),
    .imm  (dec_imm)
  );

  // Only the registered scoreboard is consulted: a same-cycle writeback does not bypass.
  assign hazard = (dec_use_rs1 & (dec_rs1 != '0) & sb_reg[dec_rs1]) |
                  (dec_use_rs2 & (dec_rs2 != '0) & sb_reg[dec_rs2]);

  // Held low while reset is asserted so fetch never sees a ready during reset.
  assign if_ready = rst_n & (~ex_valid_reg | ex_ready) & ~hazard & ~flush;
  assign accept   = if_valid & if_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign sb_next[gi] = 1'b0;
      end else begin : g_bit
        logic set_bit, clr_bit;
        assign set_bit = accept & dec_rd_we & (dec_rd == RA_W'(gi));
        assign clr_bit = wb_valid & (wb_rd_addr == RA_W'(gi));
        assign sb_next[gi] = ~flush & (set_bit | (sb_reg[gi] & ~clr_bit));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_reg <= '0;
    end else begin
      sb_reg <= sb_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg   <= 1'b0;
      ex_pc_reg      <= '0;
      ex_opcode_reg  <= '0;
      ex_funct3_reg  <= '0;
      ex_funct7_reg  <= '0;
      ex_rs1_reg     <= '0;
      ex_rs2_reg     <= '0;
      ex_rd_reg      <= '0;
      ex_rd_we_reg   <= 1'b0;
      ex_imm_reg     <= '0;
      ex_illegal_reg <= 1'b0;
    end else if (flush) begin
      ex_valid_reg   <= 1'b0;
    end else if (accept) begin
      ex_valid_reg   <= 1'b1;
      ex_pc_reg      <= if_pc;
      ex_opcode_reg  <= dec_opcode;
      ex_funct3_reg  <= if_inst[14:12];
      ex_funct7_reg  <= if_inst[31:25];
      ex_rs1_reg     <= dec_rs1;
      ex_rs2_reg     <= dec_rs2;
      ex_rd_reg      <= dec_rd;
      ex_rd_we_reg   <= dec_rd_we;
      ex_imm_reg     <= dec_imm;
      ex_illegal_reg <= dec_illegal;
    end else if (ex_ready) begin
      ex_valid_reg   <= 1'b0;
    end
  end

  assign ex_valid    = ex_valid_reg;
  assign ex_pc       = ex_pc_reg;
  assign ex_opcode   = ex_opcode_reg;
  assign ex_funct3   = ex_funct3_reg;
  assign ex_funct7   = ex_funct7_reg;
  assign ex_rs1_addr = ex_rs1_reg;
  assign ex_rs2_addr = ex_rs2_reg;
  assign ex_rd_addr  = ex_rd_reg;
  assign ex_rd_we    = ex_rd_we_reg;
  assign ex_imm      = ex_imm_reg;
  assign ex_illegal  = ex_illegal_reg;

endmodule
